// File: rtl/vend_pkg.sv
// Shared vending types: arbiter state encoding, item codes, coin denominations
// and change helpers used by the arbiter and the per-channel vending FSMs.
package vend_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_GRANT    = 3'd1,
    ST_DISPENSE = 3'd2,
    ST_CHANGE   = 3'd3,
    ST_DONE     = 3'd4,
    ST_FAULT    = 3'd5
  } vend_state_e;

  typedef logic [1:0] item_t;

  localparam logic [3:0] DENOM_5  = 4'd5;
  localparam logic [3:0] DENOM_10 = 4'd10;
  localparam logic [3:0] DENOM_15 = 4'd15;

  // The hopper only pays out whole 5-unit coins, so only these amounts are payable.
  function automatic logic change_ok(input logic [3:0] change);
    return (change == 4'd0) || (change == DENOM_5) ||
           (change == DENOM_10) || (change == DENOM_15);
  endfunction

  function automatic logic [1:0] change_coins(input logic [3:0] change);
    logic [1:0] coins;
    case (change)
      DENOM_5:  coins = 2'd1;
      DENOM_10: coins = 2'd2;
      DENOM_15: coins = 2'd3;
      default:  coins = 2'd0;
    endcase
    return coins;
  endfunction

endpackage

// File: rtl/vend_rr_picker.sv
// Combinational round-robin select: first asserted request searching from
// ptr+1 upward with wrap, so the previous winner has lowest priority.
module vend_rr_picker #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] req,
  input  logic [2:0]       ptr,
  output logic [N_REQ-1:0] grant_oh,
  output logic [2:0]       grant_idx,
  output logic             grant_valid
);

  localparam logic [N_REQ-1:0] OH0 = {{(N_REQ-1){1'b0}}, 1'b1};

  logic [7:0] req_ext;
  logic [2:0] cand;

  assign req_ext = 8'(req);

  always_comb begin
    grant_oh    = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand        = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = 3'((int'(ptr) + i) % N_REQ);
      if (!grant_valid && req_ext[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
        grant_oh    = OH0 << cand;
      end
    end
  end

endmodule

// File: rtl/vend_dispense_arbiter.sv
// Shares one dispenser motor and one change hopper among N_REQ vending channels:
// round-robin grant, motor/drop-sensor then hopper/coin-sensor sequencing, ack.
module vend_dispense_arbiter
  import vend_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int DROP_TIMEOUT = 1000,
  parameter int COIN_TIMEOUT = 200,
  parameter int TW           = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [2*N_REQ-1:0]   req_item,
  input  logic [4*N_REQ-1:0]   req_change,
  output logic [N_REQ-1:0]     req_ack,
  output logic [N_REQ-1:0]     req_err,
  output logic [1:0]           motor_sel,
  output logic                 motor_en,
  input  logic                 drop_sense,
  output logic                 hopper_en,
  input  logic                 coin_sense,
  output logic                 busy,
  output logic [2:0]           grant_id,
  output logic                 fault,
  input  logic                 fault_clr
);

  // Handshake: a channel holds req_valid (with item/change stable) until it sees
  // a one-cycle req_ack or req_err pulse on its bit; there is no separate ready.
  // Arbitration is suppressed while a response pulse is on the bus, so a channel
  // dropping req_valid in reaction to its pulse is never granted twice.

  localparam logic [N_REQ-1:0] OH0 = {{(N_REQ-1){1'b0}}, 1'b1};

  vend_state_e      state_q, state_d;
  logic [2:0]       owner_q, owner_d;
  logic [2:0]       ptr_q, ptr_d;
  item_t            item_q, item_d;
  logic [3:0]       change_q, change_d;
  logic [1:0]       coins_q, coins_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic [N_REQ-1:0] err_q, err_d;

  logic [N_REQ-1:0] win_oh;
  logic [2:0]       win_idx;
  logic             win_valid;
  logic [N_REQ-1:0] owner_oh;
  logic             resp_pending;

  vend_rr_picker #(.N_REQ(N_REQ)) u_picker (
    .req         (req_valid),
    .ptr         (ptr_q),
    .grant_oh    (win_oh),
    .grant_idx   (win_idx),
    .grant_valid (win_valid)
  );

  assign owner_oh     = OH0 << owner_q;
  assign resp_pending = (|ack_q) | (|err_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      owner_q  <= '0;
      ptr_q    <= 3'(N_REQ - 1);
      item_q   <= '0;
      change_q <= '0;
      coins_q  <= '0;
      timer_q  <= '0;
      ack_q    <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      ptr_q    <= ptr_d;
      item_q   <= item_d;
      change_q <= change_d;
      coins_q  <= coins_d;
      timer_q  <= timer_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    item_d   = item_q;
    change_d = change_q;
    coins_d  = coins_q;
    timer_d  = timer_q;
    ack_d    = '0;
    err_d    = '0;

    case (state_q)
      ST_IDLE: begin
        if (win_valid && !resp_pending) begin
          state_d = ST_GRANT;
          owner_d = win_idx;
          ptr_d   = win_idx;
          for (int j = 0; j < N_REQ; j++) begin
            if (win_oh[j]) begin
              item_d   = req_item[2*j +: 2];
              change_d = req_change[4*j +: 4];
            end
          end
        end
      end

      ST_GRANT: begin
        if (change_ok(change_q)) begin
          coins_d = change_coins(change_q);
          timer_d = '0;
          state_d = ST_DISPENSE;
        end else begin
          err_d   = owner_oh;
          state_d = ST_IDLE;
        end
      end

      ST_DISPENSE: begin
        if (drop_sense) begin
          timer_d = '0;
          state_d = (coins_q != 2'd0) ? ST_CHANGE : ST_DONE;
        end else if (timer_q == TW'(DROP_TIMEOUT - 1)) begin
          err_d   = owner_oh;
          state_d = ST_FAULT;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      // A coin arriving on the timeout cycle still counts as paid.
      ST_CHANGE: begin
        if (coin_sense) begin
          coins_d = coins_q - 2'd1;
          timer_d = '0;
          if (coins_q == 2'd1) state_d = ST_DONE;
        end else if (timer_q == TW'(COIN_TIMEOUT - 1)) begin
          err_d   = owner_oh;
          state_d = ST_FAULT;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      ST_DONE: begin
        ack_d   = owner_oh;
        state_d = ST_IDLE;
      end

      ST_FAULT: begin
        if (fault_clr) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign req_ack   = ack_q;
  assign req_err   = err_q;
  assign motor_en  = (state_q == ST_DISPENSE);
  assign motor_sel = motor_en ? item_q : 2'd0;
  assign hopper_en = (state_q == ST_CHANGE) && (coins_q != 2'd0);
  assign busy      = (state_q != ST_IDLE);
  assign grant_id  = busy ? owner_q : 3'd0;
  assign fault     = (state_q == ST_FAULT);

endmodule

// File: doc/vend_dispense_arbiter.md
Name: vend_dispense_arbiter

Overview:
- Shares one item dispenser motor and one change-return coin hopper among N_REQ vending front-end channels.
- Each channel runs its own coin/selection FSM and raises a dispense request carrying item code and change owed.
- The arbiter grants requests round-robin, sequences motor, drop sensor, hopper and coin sensor, then acknowledges the owner.
- Sits between the per-channel vending FSMs and the shared electromechanical drivers.

Parameters:
N_REQ, 4, number of requesting channels (2..8)
DROP_TIMEOUT, 1000, max cycles from motor_en rise to drop_sense before fault
COIN_TIMEOUT, 200, max cycles per coin from hopper_en to coin_sense before fault
TW, 10, timeout counter width; must hold max(DROP_TIMEOUT, COIN_TIMEOUT)

Ports:
clk  input  1  clock
reset  input  1  reset, synchronous, active-high
req_valid  input  N_REQ  per-channel dispense request, level, held until ack/err
req_item  input  2*N_REQ  item code per channel, {ch N-1 .. ch0}
req_change  input  4*N_REQ  change owed per channel in units of 1; valid values 0,5,10,15
req_ack  output  N_REQ  one-cycle pulse: transaction complete
req_err  output  N_REQ  one-cycle pulse: transaction rejected or faulted
motor_sel  output  2  item code driven to dispenser
motor_en  output  1  dispenser motor run
drop_sense  input  1  item-dropped sensor, one-cycle pulse or level
hopper_en  output  1  hopper eject enable (one coin of 5 per coin_sense)
coin_sense  input  1  coin-ejected sensor
busy  output  1  transaction in progress (any state except IDLE)
grant_id  output  3  index of current owner; 0 when idle
fault  output  1  sticky mechanism fault
fault_clr  input  1  clears fault, returns to IDLE

Behaviour:
- Reset: all outputs 0, FSM IDLE, rr pointer = N_REQ-1 so channel 0 wins first, timers and coin count 0. Reset mid-transaction aborts it with no ack/err.
- States: IDLE, GRANT, DISPENSE, CHANGE, DONE, FAULT.
- IDLE: if any req_valid, select first asserted index searching from ptr+1 with wrap. Next cycle: GRANT, grant_id = winner, ptr = winner, item/change latched.
- GRANT (1 cycle): validate latched change.
  - 0/5/10/15: coins = change/5 (0..3), go DISPENSE.
  - Other: req_err[owner] pulse, back to IDLE; no motor or hopper activity.
- DISPENSE: motor_en=1, motor_sel=item, timer counts up.
  - drop_sense=1: motor_en drops the same edge; go CHANGE if coins>0, else DONE.
  - Timer reaching DROP_TIMEOUT-1 without drop: FAULT.
- CHANGE: hopper_en=1 while coins>0; each coin_sense decrements coins and restarts timer.
  - coins hits 0: hopper_en=0, go DONE.
  - Timer reaching COIN_TIMEOUT-1: FAULT.
  - coin_sense coinciding with timeout counts as a coin, not a fault.
- DONE (1 cycle): req_ack[owner]=1, then IDLE.
  - Earliest new grant is 2 cycles after ack, so a requester lowering req_valid on ack is never regranted.
- FAULT: motor_en=hopper_en=0, fault=1, req_err[owner] pulsed once on entry. Requests are ignored. fault_clr=1 returns to IDLE, fault=0.
  - fault_clr outside FAULT has no effect.
- Owner lowering req_valid mid-transaction does not abort; ack/err still pulsed.
- Sensor pulses outside their state are ignored.
- Simultaneous requests: exactly one grant per transaction, strict round-robin. No channel waits more than N_REQ-1 transactions.
- Total latency for change 0 with drop at cycle k of DISPENSE: request to ack = k+4 cycles.

Decomposition:
- Package vend_pkg: state enum, item code typedef (2 bits), DENOM_5=4'd5, DENOM_10=4'd10, DENOM_15=4'd15 constants, shared with channel FSMs.
- One sub-module: vend_rr_picker. Combinational round-robin priority select with req vector and pointer in, one-hot/index plus valid out. Reusable by a future coin-acceptor arbiter.

Test Plan:
- Single request, ch1 item 2, change 0; drop_sense 5 cycles into DISPENSE -> motor_sel=2 while motor_en high; motor_en high for 5 cycles; req_ack[1] pulse; hopper_en never high.
- ch0 change 10 -> after drop, hopper_en high until 2 coin_sense pulses; then req_ack[0]; busy low next cycle.
- req_valid=4'b1111 held, re-raised after each ack -> grant order 0,1,2,3,0; each with one ack.
- ch2 change 7 -> req_err[2] pulse 2 cycles after request; motor_en and hopper_en stay 0; ch3 pending is granted next.
- No drop_sense -> FAULT at cycle DROP_TIMEOUT of DISPENSE; fault=1, req_err pulse, motor_en=0; pending requests not granted until fault_clr; grant then resumes at ptr+1.
- Reset asserted during CHANGE with 2 coins left -> next cycle all outputs 0, no ack/err; channel 0 wins first after reset.
